// File: rtl/rns_pkg.sv
// Shared types and constants for the binary-to-residue forward converter
// over the moduli set {2^N-1, 2^N, 2^N+1, 2^(N+1)-1}.
package rns_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEFAULT  = 8;
    localparam int NUM_CHUNKS = 5;

    function automatic int m1(input int n);
        return (1 << n) - 1;
    endfunction

    function automatic int m3(input int n);
        return (1 << n) + 1;
    endfunction

    function automatic int m4(input int n);
        return (1 << (n + 1)) - 1;
    endfunction

endpackage

// File: rtl/rns_eac_add.sv
// W-bit end-around-carry adder modulo 2^W-1; the all-ones redundant zero
// is folded to 0 so callers always see a canonical residue.
module rns_eac_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);

    logic [W:0]   w_raw;
    logic [W-1:0] w_wrap;

    always_comb begin
        w_raw  = {1'b0, i_a} + {1'b0, i_b};
        w_wrap = w_raw[W-1:0] + {{(W-1){1'b0}}, w_raw[W]};
        o_sum  = (&w_wrap) ? '0 : w_wrap;
    end

endmodule

// File: rtl/rns_fwd_conv.sv
// Serial forward converter: consumes X in N-bit chunks (MSB first) and runs
// one Horner accumulator per modulus channel, then holds the residues in DONE.
module rns_fwd_conv
    import rns_pkg::*;
#(
    parameter  int N  = N_DEFAULT,
    localparam int XW = 4 * N + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  r1,
    output logic [N-1:0]  r2,
    output logic [N:0]    r3,
    output logic [N:0]    r4
);

    localparam int          SW         = NUM_CHUNKS * N;
    localparam int          M3_INT     = m3(N);
    localparam logic [N+1:0] M3        = M3_INT[N+1:0];
    localparam logic [2:0]  LAST_CHUNK = 3'(NUM_CHUNKS - 1);

    state_t        r_state;
    state_t        w_next;
    logic [SW-1:0] r_shift;
    logic [2:0]    r_count;
    logic [N-1:0]  r_a1;
    logic [N:0]    r_a3;
    logic [N:0]    r_a4;
    logic [N-1:0]  r_r1;
    logic [N-1:0]  r_r2;
    logic [N:0]    r_r3;
    logic [N:0]    r_r4;

    logic          w_accept;
    logic          w_last;
    logic [N-1:0]  w_chunk;
    logic [N:0]    w_a4_rot;
    logic [N-1:0]  w_a1_next;
    logic [N:0]    w_a4_next;
    logic [N+1:0]  w_diff;
    logic [N+1:0]  w_diff_fix;
    logic [N:0]    w_a3_next;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_count == 3'd0);
    assign w_chunk  = r_shift[SW-1 -: N];
    // Right rotate by one is multiplication by 2^N modulo 2^(N+1)-1.
    assign w_a4_rot = {r_a4[0], r_a4[N:1]};

    rns_eac_add #(.W(N)) u_add_m1 (
        .i_a   (r_a1),
        .i_b   (w_chunk),
        .o_sum (w_a1_next)
    );

    rns_eac_add #(.W(N + 1)) u_add_m4 (
        .i_a   (w_a4_rot),
        .i_b   ({1'b0, w_chunk}),
        .o_sum (w_a4_next)
    );

    // Since 2^N is -1 modulo 2^N+1, each step is chunk minus accumulator.
    always_comb begin
        w_diff     = {2'b00, w_chunk} - {1'b0, r_a3};
        w_diff_fix = w_diff + M3;
        w_a3_next  = w_diff[N+1] ? w_diff_fix[N:0] : w_diff[N:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_count <= '0;
            r_a1    <= '0;
            r_a3    <= '0;
            r_a4    <= '0;
            r_r1    <= '0;
            r_r2    <= '0;
            r_r3    <= '0;
            r_r4    <= '0;
        end else if (w_accept) begin
            r_shift <= {{(SW-XW){1'b0}}, x};
            r_count <= LAST_CHUNK;
            r_a1    <= '0;
            r_a3    <= '0;
            r_a4    <= '0;
            r_r2    <= x[N-1:0];
        end else if (r_state == RUN) begin
            r_shift <= r_shift << N;
            r_a1    <= w_a1_next;
            r_a3    <= w_a3_next;
            r_a4    <= w_a4_next;
            if (w_last) begin
                r_r1 <= w_a1_next;
                r_r3 <= w_a3_next;
                r_r4 <= w_a4_next;
            end else begin
                r_count <= r_count - 3'd1;
            end
        end
    end

    assign r1 = r_r1;
    assign r2 = r_r2;
    assign r3 = r_r3;
    assign r4 = r_r4;

endmodule
